// File: rtl/ring_osc_meter.sv
`timescale 1ps/1ps
// ring_osc_meter: bank of NAND-gated inverter rings with a windowed edge-count frequency meter.
// One selected ring runs for 2^win_log2 clk cycles; its ring-domain edge count is captured after a settle gap.
module ring_osc_meter #(
    parameter int NUM_RINGS   = 4,
    parameter int BASE_STAGES = 20,
    parameter int COUNT_W     = 16,
    parameter int STAGE_DELAY = 250,
    localparam int SEL_W      = (NUM_RINGS > 1) ? $clog2(NUM_RINGS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [SEL_W-1:0]   ring_sel,
    input  logic [3:0]         win_log2,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] count,
    output logic               overflow,
    output logic               osc_out,
    output logic [2:0]         dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_RUN     = 3'd2,
        S_SETTLE  = 3'd3,
        S_CAPTURE = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [14:0]          win_q, win_d;
    logic [1:0]           phase_q, phase_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [NUM_RINGS-1:0] en_q, en_d;
    logic                 clr_q, clr_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ovf_q, ovf_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic [NUM_RINGS-1:0] osc;
    logic [NUM_RINGS-1:0] sel_hit;
    logic                 ring_clk;
    logic                 ctr_arst;
    logic [COUNT_W-1:0]   cnt_q;
    logic                 sat_q;

    // Handshake: start is sampled only in IDLE; busy is high from the cycle after an accepted
    // start until the cycle after done; done pulses once when count/overflow become valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            win_q   <= '0;
            phase_q <= '0;
            sel_q   <= '0;
            en_q    <= '0;
            clr_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            phase_q <= phase_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            clr_q   <= clr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        phase_d = phase_q;
        sel_d   = sel_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    win_d   = (15'd1 << win_log2) - 15'd1;
                    sel_d   = ring_sel;
                    phase_d = '0;
                end
            end
            S_CLEAR: begin
                phase_d = phase_q + 2'd1;
                if (phase_q == 2'd1) begin
                    state_d = S_RUN;
                    phase_d = '0;
                end
            end
            S_RUN: begin
                if (win_q == '0) state_d = S_SETTLE;
                else             win_d   = win_q - 15'd1;
            end
            S_SETTLE: begin
                // phase wraps back to 0 on the fourth cycle
                phase_d = phase_q + 2'd1;
                if (phase_q == 2'd3) state_d = S_CAPTURE;
            end
            S_CAPTURE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Enables and clear are registered from the next state so they are glitch-free.
    always_comb begin
        en_d    = '0;
        sel_hit = '0;
        for (int k = 0; k < NUM_RINGS; k++) begin
            en_d[k]    = (state_d == S_RUN) && (sel_d == SEL_W'(k));
            sel_hit[k] = (sel_q == SEL_W'(k));
        end
        clr_d   = (state_d == S_CLEAR);
        busy_d  = (state_q != S_IDLE);
        done_d  = (state_q == S_CAPTURE);
        count_d = done_d ? cnt_q : count_q;
        ovf_d   = done_d ? sat_q : ovf_q;
    end

    for (genvar k = 0; k < NUM_RINGS; k++) begin : g_ring
        localparam int N = BASE_STAGES * (k + 1);
        logic nand_y;
        logic last;
        // The whole loop delay is lumped onto the NAND so the inverter chain stays plain logic.
        assign #(STAGE_DELAY * (N + 1)) nand_y = ~(en_q[k] & last);
        for (genvar i = 0; i < N; i++) begin : g_inv
            logic y;
            if (i == 0) begin : g_head
                assign y = ~nand_y;
            end else begin : g_tail
                assign y = ~g_inv[i - 1].y;
            end
        end
        assign last   = g_inv[N - 1].y;
        assign osc[k] = g_inv[0].y;
    end

    assign ring_clk = |(osc & sel_hit);
    assign ctr_arst = ~rst_n | clr_q;

    always_ff @(posedge ring_clk or posedge ctr_arst) begin
        if (ctr_arst) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else if (&cnt_q) begin
            sat_q <= 1'b1;
        end else begin
            cnt_q <= cnt_q + COUNT_W'(1);
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign osc_out   = ring_clk & (|en_q);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ring_osc_meter.sv
`timescale 1ns/1ps
// Bench for ring_osc_meter: a 16-bit and an 8-bit meter checked against an ideal edge-rate model.
module tb_ring_osc_meter;

  localparam int  BASE   = 20;
  localparam real TCLK   = 10.0;
  localparam real TSTAGE = 0.25;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [1:0]  ring_sel_a = '0, ring_sel_b = '0;
  logic [3:0]  win_log2_a = '0, win_log2_b = '0;
  logic        busy_a, busy_b, done_a, done_b, overflow_a, overflow_b, osc_out_a, osc_out_b;
  logic [15:0] count_a;
  logic [7:0]  count_b;
  logic [2:0]  dbg_state_a, dbg_state_b;

  int n_tests = 0;
  int n_fail = 0;

  ring_osc_meter u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .ring_sel(ring_sel_a), .win_log2(win_log2_a),
    .busy(busy_a), .done(done_a), .count(count_a), .overflow(overflow_a),
    .osc_out(osc_out_a), .dbg_state(dbg_state_a)
  );

  ring_osc_meter #(.COUNT_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .ring_sel(ring_sel_b), .win_log2(win_log2_b),
    .busy(busy_b), .done(done_b), .count(count_b), .overflow(overflow_b),
    .osc_out(osc_out_b), .dbg_state(dbg_state_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, limit 2 ms");
    $fatal(1);
  end

  // Ideal number of ring periods that fit in the measurement window.
  function automatic real model_edges(int k, int n);
    real period;
    period = 2.0 * real'(BASE * (k + 1) + 1) * TSTAGE;
    return real'(1 << n) * TCLK / period;
  endfunction

  function automatic bit near(int act, real exp_v);
    real d;
    d = real'(act) - exp_v;
    if (d < 0.0) d = -d;
    return d <= 2.0;
  endfunction

  task automatic measure(input bit wide, input int sel, input int n,
                         output int lat, output int busy_n, output int cnt, output bit ovf);
    int limit;
    limit = (1 << n) + 40;
    @(negedge clk);
    if (wide) begin
      start_a = 1'b1; ring_sel_a = 2'(sel); win_log2_a = 4'(n);
    end else begin
      start_b = 1'b1; ring_sel_b = 2'(sel); win_log2_b = 4'(n);
    end
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    busy_n = (wide ? busy_a : busy_b) ? 1 : 0;
    lat = -1;
    for (int c = 1; c <= limit; c++) begin
      @(posedge clk); #1;
      if (wide ? busy_a : busy_b) busy_n++;
      if (wide ? done_a : done_b) begin
        lat = c;
        break;
      end
    end
    @(posedge clk); #1;
    if (wide ? busy_a : busy_b) busy_n++;
    cnt = wide ? int'(count_a) : int'(count_b);
    ovf = wide ? overflow_a : overflow_b;
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_tests++;
    if ({busy_a, done_a, overflow_a, osc_out_a, count_a} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_outputs_a: got %0h expected 0", {busy_a, done_a, overflow_a, osc_out_a, count_a});
    end
    n_tests++;
    if ({busy_b, done_b, overflow_b, osc_out_b, count_b} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_outputs_b: got %0h expected 0", {busy_b, done_b, overflow_b, osc_out_b, count_b});
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk); #1;
      if (osc_out_a !== 1'b0 || osc_out_b !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL idle_quiet: got %0d active cycles expected 0", bad);
    end
    n_tests++;
    if (dbg_state_a !== 3'd0) begin
      n_fail++;
      $display("FAIL idle_state: got %0d expected 0", dbg_state_a);
    end
  endtask

  task automatic test_basic();
    int lat, bn, cnt;
    bit ovf;
    measure(1'b1, 0, 6, lat, bn, cnt, ovf);
    n_tests++;
    if (lat !== 71) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d expected 71", lat);
    end
    n_tests++;
    if (bn !== 71) begin
      n_fail++;
      $display("FAIL basic_busy_cycles: got %0d expected 71", bn);
    end
    n_tests++;
    if (cnt < 59 || cnt > 63 || !near(cnt, model_edges(0, 6))) begin
      n_fail++;
      $display("FAIL basic_count: got %0d expected 59..63", cnt);
    end
    n_tests++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_overflow: got %0d expected 0", ovf);
    end
  endtask

  task automatic test_ring_scaling();
    int lat, bn, cnt, prev;
    bit ovf;
    prev = 1 << 30;
    for (int k = 0; k < 4; k++) begin
      measure(1'b1, k, 8, lat, bn, cnt, ovf);
      n_tests++;
      if (!near(cnt, model_edges(k, 8)) || ovf !== 1'b0) begin
        n_fail++;
        $display("FAIL scaling_ring%0d: got %0d ovf %0d expected %0.1f ovf 0", k, cnt, ovf, model_edges(k, 8));
      end
      n_tests++;
      if (!(cnt < prev)) begin
        n_fail++;
        $display("FAIL scaling_order_ring%0d: got %0d expected below %0d", k, cnt, prev);
      end
      prev = cnt;
    end
  endtask

  task automatic test_random();
    int lat, bn, cnt, k, n;
    bit ovf;
    for (int it = 0; it < 6; it++) begin
      k = $urandom_range(0, 3);
      n = $urandom_range(0, 7);
      measure(1'b1, k, n, lat, bn, cnt, ovf);
      n_tests++;
      if (lat !== 7 + (1 << n)) begin
        n_fail++;
        $display("FAIL random_latency ring%0d win%0d: got %0d expected %0d", k, n, lat, 7 + (1 << n));
      end
      n_tests++;
      if (!near(cnt, model_edges(k, n)) || ovf !== 1'b0) begin
        n_fail++;
        $display("FAIL random_count ring%0d win%0d: got %0d ovf %0d expected %0.1f ovf 0", k, n, cnt, ovf, model_edges(k, n));
      end
    end
  endtask

  task automatic test_overflow();
    int lat, bn, cnt;
    bit ovf;
    measure(1'b0, 0, 10, lat, bn, cnt, ovf);
    n_tests++;
    if (cnt !== 255 || ovf !== 1'b1 || lat !== 1031) begin
      n_fail++;
      $display("FAIL overflow_sat: got count %0d ovf %0d lat %0d expected 255 1 1031", cnt, ovf, lat);
    end
    measure(1'b0, 0, 4, lat, bn, cnt, ovf);
    n_tests++;
    if (!near(cnt, model_edges(0, 4)) || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_followup: got count %0d ovf %0d expected %0.1f ovf 0", cnt, ovf, model_edges(0, 4));
    end
  endtask

  task automatic test_handshake();
    int dones, done_at;
    @(negedge clk);
    start_a = 1'b1; ring_sel_a = 2'd1; win_log2_a = 4'd4;
    @(posedge clk); #1;
    ring_sel_a = 2'd3; win_log2_a = 4'd9;
    dones = 0;
    done_at = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (done_a) begin
        dones++;
        if (done_at < 0) done_at = c;
      end
      start_a = (c == 10 || c == 19);
    end
    start_a = 1'b0;
    n_tests++;
    if (dones !== 1 || done_at !== 23) begin
      n_fail++;
      $display("FAIL handshake_done: got %0d dones at %0d expected 1 at 23", dones, done_at);
    end
    n_tests++;
    if (!near(int'(count_a), model_edges(1, 4))) begin
      n_fail++;
      $display("FAIL handshake_latched_sel: got %0d expected %0.1f", count_a, model_edges(1, 4));
    end
    n_tests++;
    if (busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL handshake_busy_end: got %0d expected 0", busy_a);
    end
  endtask

  task automatic test_back_to_back();
    int dones, d1, d2;
    logic b12, b13, b30;
    @(negedge clk);
    start_a = 1'b1; ring_sel_a = 2'd0; win_log2_a = 4'd2;
    @(posedge clk); #1;
    dones = 0; d1 = -1; d2 = -1;
    b12 = 1'bx; b13 = 1'bx; b30 = 1'bx;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done_a) begin
        dones++;
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
      if (c == 12) begin
        b12 = busy_a;
        start_a = 1'b0;
      end
      if (c == 13) b13 = busy_a;
      if (c == 30) b30 = busy_a;
    end
    n_tests++;
    if (dones !== 2 || d1 !== 11 || d2 !== 23) begin
      n_fail++;
      $display("FAIL b2b_done: got %0d dones at %0d,%0d expected 2 at 11,23", dones, d1, d2);
    end
    n_tests++;
    if ({b12, b13, b30} !== 3'b010) begin
      n_fail++;
      $display("FAIL b2b_busy_gap: got %b expected 010", {b12, b13, b30});
    end
  endtask

  task automatic test_reset_mid_run();
    int dones, lat, bn, cnt;
    bit ovf;
    @(negedge clk);
    start_a = 1'b1; ring_sel_a = 2'd0; win_log2_a = 4'd6;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #0.5;
    n_tests++;
    if ({busy_a, done_a, overflow_a, osc_out_a, count_a, dbg_state_a} !== 23'd0) begin
      n_fail++;
      $display("FAIL midrun_reset: got busy %0d done %0d ovf %0d osc %0d count %0d state %0d expected all 0",
               busy_a, done_a, overflow_a, osc_out_a, count_a, dbg_state_a);
    end
    #0.5;
    rst_n = 1'b1;
    dones = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (done_a) dones++;
    end
    n_tests++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL midrun_no_done: got %0d expected 0", dones);
    end
    measure(1'b1, 1, 6, lat, bn, cnt, ovf);
    n_tests++;
    if (lat !== 71 || !near(cnt, model_edges(1, 6)) || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_recover: got lat %0d count %0d ovf %0d expected 71 %0.1f 0", lat, cnt, ovf, model_edges(1, 6));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ring_scaling();
    test_random();
    test_overflow();
    test_handshake();
    test_back_to_back();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ring_osc_meter.md
# ring_osc_meter

Parametrised multi-ring oscillator bank with an on-chip frequency meter for the Tiny Tapeout tile. It holds `NUM_RINGS` NAND-gated inverter rings of increasing length. It enables one selected ring for a programmable window of `clk` cycles and counts that ring's rising edges in the ring domain. When the window closes, the ring is stopped and the count is returned to the `clk` domain through a start/busy/done handshake. It succeeds the single free-running ring with a raw output pin: it adds ring selection, gated operation and on-chip measurement.

## Interface
- `NUM_RINGS`, 4: number of rings. Ring k has `BASE_STAGES*(k+1)` inverters plus one enable NAND.
- `BASE_STAGES`, 20: inverters per length unit. Must be even, so each loop has an odd number of inversions.
- `COUNT_W`, 16: edge-counter and result width.
- `STAGE_DELAY`, 250 (ps): per-element delay of the behavioural ring model. Simulation only; ignored by synthesis.
- `clk` input 1: reference clock. All control logic runs on its rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `start` input 1: request a measurement. Sampled only in IDLE.
- `ring_sel` input `$clog2(NUM_RINGS)`: ring to measure. Captured on an accepted start.
- `win_log2` input 4: window length is 2^`win_log2` clk cycles (1..32768). Captured on an accepted start.
- `busy` output 1: high from the cycle after an accepted start until the cycle after `done`.
- `done` output 1: one-cycle pulse when `count` and `overflow` become valid.
- `count` output `COUNT_W`: rising edges of the selected ring during the last window.
- `overflow` output 1: the last measurement saturated `count`.
- `osc_out` output 1: the selected ring's output, raw, for pin observation. Low when the ring is disabled.

## Operation
- Each ring loop is NAND(`en_k`, last stage) -> inverters -> back to the NAND input. With `en_k`=0 the NAND output is 1 and the ring holds static. Only the selected ring ever has `en_k`=1.
- Edge counter:
  - `COUNT_W` bits, clocked by the selected ring's output (after a one-hot mux).
  - Asynchronously cleared by `rst_n`=0 or `ctr_clr`=1.
  - Saturates at all-ones and sets the ring-domain `sat` flag.
- FSM states: IDLE, CLEAR, RUN, SETTLE, CAPTURE.
  - IDLE: all `en_k`=0. On `start`=1, latch `ring_sel` and `win_log2`, load the window counter with 2^`win_log2`-1, and go to CLEAR.
  - CLEAR (2 cycles): `ctr_clr`=1, ring disabled. Then go to RUN.
  - RUN: `en_sel`=1 and the window counter decrements each cycle. When it reads 0, go to SETTLE. RUN therefore lasts exactly 2^`win_log2` cycles.
  - SETTLE (4 cycles): ring disabled. The ring decays and the counter quiesces, so no synchroniser is needed on the multi-bit count. Then go to CAPTURE.
  - CAPTURE (1 cycle): latch the edge counter into `count` and `sat` into `overflow`, pulse `done`=1, return to IDLE.
- `start` outside IDLE is ignored, not queued. `start` held high re-triggers a new measurement on the IDLE cycle after `done`.
- A `ring_sel` value ≥ `NUM_RINGS` selects no ring: the measurement completes normally with `count`=0 and `overflow`=0.
- `count` and `overflow` hold their values until the next CAPTURE.

## Timing
- Reset values: FSM=IDLE, `busy`=0, `done`=0, `count`=0, `overflow`=0, `osc_out`=0, all rings disabled, edge counter cleared.
- Reset mid-measurement: everything returns to the reset values immediately (asynchronously). The ring stops, and no `done` pulse is issued.
- Latency from the `start` sample edge to `done` high is 2 + 2^`win_log2` + 4 + 1 cycles (`win_log2`=6 gives 71).
- `busy` rises one cycle after the start edge and falls the cycle after `done`. The earliest next accepted start is the edge on which `busy` is observed low.
- Expected count ≈ 2^`win_log2`·T_clk / (2·(`BASE_STAGES`·(k+1)+1)·`STAGE_DELAY`). Tolerance is ±2 to cover enable/disable edge phasing.

## Test plan
- Reset and idle:
  - Stimulus: `rst_n`=0, release, no start.
  - Required: outputs are all 0 and `osc_out` stays 0 for 1000 cycles.
- Basic measurement:
  - Stimulus: T_clk=10 ns, `ring_sel`=0 (period 10.5 ns), `win_log2`=6.
  - Required: `done` on cycle 71, `count` in 59..63, `overflow`=0, `busy` high for exactly 71 cycles.
- Ring scaling:
  - Stimulus: `win_log2`=8, `ring_sel`=0..3 (periods 10.5, 20.5, 30.5, 40.5 ns).
  - Required: counts ≈ 244, 125, 84, 63, each ±2, strictly decreasing.
- Overflow:
  - Stimulus: `COUNT_W`=8, `ring_sel`=0, `win_log2`=10.
  - Required: `count`=255, `overflow`=1.
  - Follow-up: `win_log2`=4 then gives `overflow`=0, `count`≈15.
- Handshake:
  - Stimulus: start pulses during CLEAR, RUN and SETTLE.
  - Required: ignored, with exactly one `done`. Start held high gives back-to-back measurements separated by one IDLE cycle.
- Reset mid-RUN:
  - Stimulus: assert `rst_n` for 1 ns at cycle 30 of a `win_log2`=6 run.
  - Required: immediate `busy`=0, `count`=0, `osc_out`=0, no `done`. A subsequent start measures normally.
